// File: rtl/median_pkg.sv
// Shared constants and compare helper for the parameterised sliding-window median filter.
package median_pkg;

  localparam int MAX_WINDOW        = 7;
  localparam int MAX_WIDTH         = 16;
  localparam int RANK_W            = 3;
  localparam int NUM_LEGAL_WINDOWS = 3;
  localparam int LEGAL_WINDOWS [NUM_LEGAL_WINDOWS] = '{3, 5, 7};

  typedef logic [RANK_W-1:0] rank_t;

  function automatic bit is_legal_window(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WINDOWS; i++) begin
      if (LEGAL_WINDOWS[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

  // a < b via one extra bit of subtract headroom; operands arrive left-justified
  // in MAX_WIDTH bits, which preserves ordering for both signed and unsigned data.
  function automatic logic med_less(input logic [MAX_WIDTH-1:0] a,
                                    input logic [MAX_WIDTH-1:0] b,
                                    input logic                 signed_mode);
    logic [MAX_WIDTH:0] a_x;
    logic [MAX_WIDTH:0] b_x;
    logic [MAX_WIDTH:0] diff;
    a_x  = {signed_mode & a[MAX_WIDTH-1], a};
    b_x  = {signed_mode & b[MAX_WIDTH-1], b};
    diff = a_x - b_x;
    return diff[MAX_WIDTH];
  endfunction

endpackage

// File: rtl/median_filter_param_rank.sv
// Combinational rank-based median selector: pairwise comparator matrix plus one-hot rank mux.
module median_rank_select
  import median_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 3,
  parameter int SIGNED = 1
) (
  input  logic [WINDOW*WIDTH-1:0] win_vec,
  output logic [WIDTH-1:0]        med
);

  localparam int    PAD      = MAX_WIDTH - WIDTH;
  localparam logic  SMODE    = (SIGNED != 0);
  localparam rank_t MID_RANK = rank_t'((WINDOW - 1) / 2);

  logic [MAX_WIDTH-1:0] key  [WINDOW];
  logic [WINDOW-1:0]    lt   [WINDOW];
  rank_t                rank [WINDOW];
  logic [WINDOW-1:0]    hit;

  always_comb begin
    for (int j = 0; j < WINDOW; j++) begin
      key[j] = MAX_WIDTH'(win_vec[j*WIDTH +: WIDTH]) << PAD;
    end
  end

  // lt[j][k] is set when element k sorts strictly below element j
  always_comb begin
    for (int j = 0; j < WINDOW; j++) begin
      for (int k = 0; k < WINDOW; k++) begin
        lt[j][k] = (k != j) && med_less(key[k], key[j], SMODE);
      end
    end
  end

  // Equal values are ordered by index, so exactly one element owns the middle rank.
  always_comb begin
    med = '0;
    hit = '0;
    for (int j = 0; j < WINDOW; j++) begin
      rank[j] = '0;
      for (int k = 0; k < WINDOW; k++) begin
        if (lt[j][k] || ((k < j) && (key[k] == key[j]))) begin
          rank[j] = rank[j] + rank_t'(1);
        end
      end
      hit[j] = (rank[j] == MID_RANK);
      if (hit[j]) med = med | win_vec[j*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/median_filter_param.sv
// Streaming sliding-window median filter with valid handshake, fill tracking and sync clear.
module median_filter_param
  import median_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 3,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             win_full
);

  if (!is_legal_window(WINDOW)) begin : g_bad_window
    $error("median_filter_param: WINDOW must be 3, 5 or 7");
  end
  if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("median_filter_param: WIDTH must be in 2..16");
  end

  localparam rank_t FULL_CNT  = rank_t'(WINDOW);
  localparam rank_t LAST_FILL = rank_t'(WINDOW - 1);

  logic [WIDTH-1:0]        tap [WINDOW];
  rank_t                   fill_cnt;
  logic [WINDOW*WIDTH-1:0] win_vec_p0;
  logic [WIDTH-1:0]        med_p0;
  logic                    fire_p0;
  logic [WIDTH-1:0]        out_data_p1;
  logic                    vld_p1;

  // ---- stage p0: window assembly (new sample + older taps) and median select ----
  always_comb begin
    win_vec_p0[WIDTH-1:0] = in_data;
    for (int i = 1; i < WINDOW; i++) begin
      win_vec_p0[i*WIDTH +: WIDTH] = tap[i-1];
    end
  end

  assign fire_p0 = in_valid && (fill_cnt >= LAST_FILL);

  median_rank_select #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .SIGNED (SIGNED)
  ) u_rank (
    .win_vec (win_vec_p0),
    .med     (med_p0)
  );

  // ---- stage p1: taps, fill counter and output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WINDOW; i++) tap[i] <= '0;
      fill_cnt    <= '0;
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
    end else if (clear) begin
      fill_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= fire_p0;
      if (fire_p0) out_data_p1 <= med_p0;
      if (in_valid) begin
        tap[0] <= in_data;
        for (int i = 1; i < WINDOW; i++) tap[i] <= tap[i-1];
        if (fill_cnt != FULL_CNT) fill_cnt <= fill_cnt + rank_t'(1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = out_data_p1;
  assign win_full  = (fill_cnt == FULL_CNT);

endmodule
